// File: rtl/pc_sequencer_if.sv
// Control-unit to PC-sequencer bundle: next-PC selects, targets, stall/interrupt
// qualifiers in; PC, EPC and status out.
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 32
);
  logic [1:0]      pcSource;
  logic [15:0]     branchAddr;
  logic [25:0]     jumpAddr;
  logic [PC_W-1:0] regAddr;
  logic            isHalt;
  logic            isInsert;
  logic            inputAck;
  logic            intr;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pcPlusOne;
  logic [PC_W-1:0] epc;
  logic            stall;
  logic            intrTaken;

  modport master (
    output pcSource, branchAddr, jumpAddr, regAddr, isHalt, isInsert, inputAck, intr,
    input  pc, pcPlusOne, epc, stall, intrTaken
  );

  modport slave (
    input  pcSource, branchAddr, jumpAddr, regAddr, isHalt, isInsert, inputAck, intr,
    output pc, pcPlusOne, epc, stall, intrTaken
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: sequential advance, jumps/branches, HALT freeze,
// IN-instruction wait on an acknowledge edge, and interrupt entry with EPC capture.
module pc_sequencer #(
  parameter int unsigned     PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter logic [PC_W-1:0] INTR_VECTOR  = PC_W'(1)
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StRun, StWaitInput, StHalted} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] epc_q;
  logic            intr_taken_q;
  logic            ack_q;
  logic [PC_W-1:0] pc_plus_one;
  logic [PC_W-1:0] next_seq;
  logic            ack_rise;

  assign pc_plus_one = pc_q + PC_W'(1);
  assign ack_rise    = bus.inputAck & ~ack_q;

  always_comb begin
    next_seq = pc_plus_one;
    case (bus.pcSource)
      2'b00:   next_seq = pc_plus_one;
      2'b01:   next_seq = PC_W'(bus.branchAddr);
      2'b10:   next_seq = bus.regAddr;
      default: next_seq = PC_W'(bus.jumpAddr);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      intr_taken_q <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      // ack_q tracks the switch in every state so a level held from before the
      // wait cannot count as a fresh confirmation.
      ack_q        <= bus.inputAck;
      intr_taken_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (bus.isHalt) begin
            state_q <= StHalted;
          end else if (bus.isInsert) begin
            state_q <= StWaitInput;
          end else if (bus.intr) begin
            epc_q        <= next_seq;
            pc_q         <= INTR_VECTOR;
            intr_taken_q <= 1'b1;
          end else begin
            pc_q <= next_seq;
          end
        end
        StWaitInput: begin
          if (ack_rise) begin
            pc_q    <= pc_plus_one;
            state_q <= StRun;
          end
        end
        StHalted: begin
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pcPlusOne = pc_plus_one;
  assign bus.epc       = epc_q;
  assign bus.stall     = (state_q != StRun);
  assign bus.intrTaken = intr_taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: advance, targets, wrap, input wait, interrupts,
// halt and reset recovery.
module tb_pc_sequencer;
  localparam int unsigned PC_W = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.pcSource   = 2'b00;
    bus.branchAddr = '0;
    bus.jumpAddr   = '0;
    bus.regAddr    = '0;
    bus.isHalt     = 1'b0;
    bus.isInsert   = 1'b0;
    bus.inputAck   = 1'b0;
    bus.intr       = 1'b0;
  endtask

  task automatic jump_to(input logic [25:0] tgt);
    bus.pcSource = 2'b11;
    bus.jumpAddr = tgt;
    step();
    bus.pcSource = 2'b00;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("rst_intrTaken", {31'b0, bus.intrTaken}, 32'h0);
    chk("rst_pcPlusOne", bus.pcPlusOne, 32'h1);

    step(); chk("seq_pc1", bus.pc, 32'h1);
    step(); chk("seq_pc2", bus.pc, 32'h2);
    step(); chk("seq_pc3", bus.pc, 32'h3);
    chk("seq_stall", {31'b0, bus.stall}, 32'h0);
    step(); step(); chk("seq_pc5", bus.pc, 32'h5);

    // Target selection and zero extension
    bus.pcSource = 2'b11; bus.jumpAddr = 26'h0000123;
    step(); chk("jump", bus.pc, 32'h123);
    bus.pcSource = 2'b01; bus.branchAddr = 16'hFFFF;
    step(); chk("branch_zext", bus.pc, 32'h0000FFFF);
    bus.pcSource = 2'b10; bus.regAddr = 32'hDEADBEEF;
    step(); chk("reg", bus.pc, 32'hDEADBEEF);
    bus.regAddr = 32'hFFFFFFFF;
    step(); chk("reg_ones", bus.pc, 32'hFFFFFFFF);
    chk("wrap_pcPlusOne", bus.pcPlusOne, 32'h0);
    bus.pcSource = 2'b00;
    step(); chk("wrap_pc", bus.pc, 32'h0);
    chk("epc_untouched", bus.epc, 32'h0);

    // IN instruction with the switch already held high
    jump_to(26'd7);
    chk("ins_pc7", bus.pc, 32'h7);
    bus.inputAck = 1'b1;
    step(); chk("ins_pc8_pre", bus.pc, 32'h8);
    jump_to(26'd7);
    bus.isInsert = 1'b1;
    step(); chk("wait_pc", bus.pc, 32'h7);
    chk("wait_stall", {31'b0, bus.stall}, 32'h1);
    bus.isInsert = 1'b0;
    bus.intr = 1'b1;
    step(); chk("wait_held_pc", bus.pc, 32'h7);
    chk("wait_held_stall", {31'b0, bus.stall}, 32'h1);
    chk("wait_no_intr", {31'b0, bus.intrTaken}, 32'h0);
    bus.inputAck = 1'b0;
    step(); chk("wait_low_pc", bus.pc, 32'h7);
    bus.inputAck = 1'b1;
    step(); chk("ack_pc", bus.pc, 32'h8);
    chk("ack_stall", {31'b0, bus.stall}, 32'h0);
    chk("ack_epc", bus.epc, 32'h0);
    step(); chk("pend_intr_pc", bus.pc, 32'h1);
    chk("pend_intr_epc", bus.epc, 32'h9);
    chk("pend_intr_pulse", {31'b0, bus.intrTaken}, 32'h1);
    bus.intr = 1'b0;
    step(); chk("pend_intr_pulse_end", {31'b0, bus.intrTaken}, 32'h0);
    chk("post_intr_pc", bus.pc, 32'h2);

    // Interrupt together with a jump: EPC gets the jump target
    jump_to(26'd10);
    chk("pc10", bus.pc, 32'd10);
    bus.pcSource = 2'b11; bus.jumpAddr = 26'd40; bus.intr = 1'b1;
    step(); chk("ij_pc", bus.pc, 32'h1);
    chk("ij_epc", bus.epc, 32'd40);
    chk("ij_pulse", {31'b0, bus.intrTaken}, 32'h1);
    bus.intr = 1'b0; bus.pcSource = 2'b00;
    step(); chk("ij_pulse_end", {31'b0, bus.intrTaken}, 32'h0);
    chk("ij_pc_next", bus.pc, 32'h2);
    chk("ij_epc_hold", bus.epc, 32'd40);

    // Halt beats interrupt, then every input is ignored until reset
    jump_to(26'd20);
    bus.isHalt = 1'b1; bus.intr = 1'b1;
    step(); chk("halt_pc", bus.pc, 32'd20);
    chk("halt_stall", {31'b0, bus.stall}, 32'h1);
    chk("halt_epc", bus.epc, 32'd40);
    chk("halt_no_pulse", {31'b0, bus.intrTaken}, 32'h0);
    for (int i = 0; i < 12; i++) begin
      bus.pcSource   = 2'($urandom_range(0, 3));
      bus.branchAddr = 16'($urandom);
      bus.jumpAddr   = 26'($urandom);
      bus.regAddr    = $urandom;
      bus.isHalt     = 1'($urandom_range(0, 1));
      bus.isInsert   = 1'($urandom_range(0, 1));
      bus.inputAck   = 1'(i & 1);
      bus.intr       = 1'($urandom_range(0, 1));
      step();
      chk("halted_pc", bus.pc, 32'd20);
      chk("halted_stall", {31'b0, bus.stall}, 32'h1);
      chk("halted_epc", bus.epc, 32'd40);
    end
    clear_inputs();
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("halt_rst_pc", bus.pc, 32'h0);
    chk("halt_rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("halt_rst_epc", bus.epc, 32'h0);

    // Reset while waiting for input
    jump_to(26'd30);
    bus.isInsert = 1'b1;
    step(); chk("w30_pc", bus.pc, 32'd30);
    chk("w30_stall", {31'b0, bus.stall}, 32'h1);
    bus.isInsert = 1'b0;
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("w30_rst_pc", bus.pc, 32'h0);
    chk("w30_rst_stall", {31'b0, bus.stall}, 32'h0);
    bus.inputAck = 1'b1;
    step(); chk("w30_ack_pc", bus.pc, 32'h1);
    chk("w30_ack_stall", {31'b0, bus.stall}, 32'h0);
    step(); chk("w30_run_pc", bus.pc, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the instruction-decode control unit.
- Consumes that unit's pcSource, isHalt, isInsert and reset outputs, plus the interrupt request, and owns the PC register that addresses instruction memory.
- Sequences normal advance, jumps and branches, HALT freeze, the INSERT input wait and interrupt entry; captures the return address in an EPC register.
- Single-cycle core: one instruction per clock unless stalled.

Parameters:
- PC_W, 32, width of PC, EPC and target buses.
- RESET_VECTOR, 0, PC value loaded on reset.
- INTR_VECTOR, 1, PC value loaded on interrupt entry.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset (driven by control unit reset output).
- pcSource  input  2  next-PC select: 00 PC+1, 01 branchAddr, 10 regAddr, 11 jumpAddr.
- branchAddr  input  16  jf target, zero-extended.
- jumpAddr  input  26  j/jal/jtm/exec target, zero-extended.
- regAddr  input  PC_W  register/ALU-supplied target (jr, syscall, exec_again).
- isHalt  input  1  current instruction is HALT.
- isInsert  input  1  current instruction is IN waiting for user input.
- inputAck  input  1  user confirm, level from debounced switch; rising edge used.
- intr  input  1  interrupt request, level, held by interrupt controller until cleared.
- pc  output  PC_W  current instruction address.
- pcPlusOne  output  PC_W  pc+1, combinational, for jal link.
- epc  output  PC_W  saved return address of last interrupt.
- stall  output  1  high while PC is frozen (HALT or WAIT_INPUT).
- intrTaken  output  1  one-cycle pulse on the cycle interrupt entry is committed.

Behaviour:
- States: RUN, WAIT_INPUT, HALTED.
- Reset values: pc=RESET_VECTOR, epc=0, state=RUN, intrTaken=0, inputAck edge register=0. Reset has priority over every other event, including mid-WAIT_INPUT and HALTED.
- nextSeq = mux(pcSource), with the zero-extended targets defined in Ports.
- PC+1 wraps from all-ones to 0 with no flag.
- RUN priority is isHalt > isInsert > intr > normal:
  - isHalt: pc holds; go HALTED.
  - isInsert: pc holds; go WAIT_INPUT.
  - intr: epc<=nextSeq; pc<=INTR_VECTOR; intrTaken=1 for that cycle; stay RUN. The current instruction completes before entry.
  - Otherwise: pc<=nextSeq.
- WAIT_INPUT:
  - stall=1; pc holds; intr is ignored (remains pending).
  - Rising edge of inputAck (registered previous value 0, current 1): pc<=pc+1; go RUN.
  - Holding inputAck high does not retrigger.
  - A pending intr is taken in the first RUN cycle where its conditions hold.
- HALTED: stall=1; pc holds; every input except reset is ignored. Exit is only by reset.
- stall=0 in RUN. stall is combinational from state.
- Latency: a PC change becomes visible on pc one clock after the deciding instruction's cycle. pcPlusOne tracks pc with zero latency.
- Writes to epc occur only on interrupt entry; epc is never otherwise modified.
- Simultaneous interrupt entry with a jump: epc captures the jump target, not pc+1.
- Simultaneous isHalt and intr: halt wins; intr is not taken and epc is unchanged.

Test Plan:
- Reset then 3 cycles pcSource=00 -> pc 0,1,2,3; epc=0; stall=0.
- pc=5, pcSource=11, jumpAddr=0x0000123 -> next pc=0x123. pcSource=01, branchAddr=0xFFFF -> pc=0x0000FFFF (zero-extended). pcSource=10, regAddr=0xDEADBEEF -> pc=0xDEADBEEF; with pcSource=00, pc wraps to 0.
- pc=7, isInsert=1 with inputAck already high -> pc stays 7, stall=1 until inputAck falls and rises again. On that edge, pc=8, stall=0. intr asserted during the wait is taken on the following RUN cycle: epc=9, pc=1.
- pc=10, pcSource=11, jumpAddr=40, intr=1 -> pc=1, epc=40, intrTaken pulses one cycle.
- pc=20, isHalt=1 and intr=1 together -> pc stays 20, epc unchanged, stall=1 for 10+ cycles with arbitrary inputs. Asserting reset then gives pc=0, stall=0.
- reset asserted during WAIT_INPUT at pc=30 -> next cycle pc=0, state RUN; a subsequent inputAck edge has no effect.
